// File: rtl/pet_action_ctrl.sv
// Pet action controller: arbitrates timed actions and keeps one saturating need stat per action.
// Optional per-stat alert flags with hysteresis are built when PET_STAT_ALERT_EN is defined.
//
//   state  | meaning
//   IDLE   | no action running, waiting for a request
//   ACT    | latched action running, duration counter advancing
//   DONE   | action completed, waiting for its request to drop
module pet_action_ctrl #(
    parameter int NUM_ACTIONS   = 4,
    parameter int STAT_W        = 8,
    parameter int STAT_MAX      = 255,
    parameter int RISE_STEP     = 1,
    parameter int FALL_STEP     = 4,
    parameter int TICK_CYCLES   = 50_000_000,
    parameter int ACTION_CYCLES = 250_000_000,
    parameter int ALERT_LEVEL   = 200,
    localparam int ID_W         = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_ACTIONS-1:0]        act_req,
    input  logic                          act_abort,
    output logic [NUM_ACTIONS*STAT_W-1:0] stats,
    output logic                          busy,
    output logic [ID_W-1:0]               active_id,
    output logic                          done,
    output logic                          aborted,
    output logic                          tick,
    output logic [NUM_ACTIONS-1:0]        alert
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DUR_W  = (ACTION_CYCLES > 1) ? $clog2(ACTION_CYCLES) : 1;
    localparam logic [STAT_W:0] RISE_V = (STAT_W+1)'(RISE_STEP);
    localparam logic [STAT_W:0] FALL_V = (STAT_W+1)'(FALL_STEP);
    localparam logic [STAT_W:0] MAX_V  = (STAT_W+1)'(STAT_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_DONE} state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic [STAT_W-1:0]   stat_q [NUM_ACTIONS];
    logic [STAT_W-1:0]   stat_d [NUM_ACTIONS];
    logic [ID_W-1:0]     first_id;

    assign tick = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
    assign busy = (state == S_ACT);
    assign done = (state == S_DONE);

    always_comb begin
        first_id = '0;
        for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
            if (act_req[i]) first_id = ID_W'(i);
        end
    end

    // Extra MSB catches both the ceiling overshoot and the borrow on the way down.
    for (genvar g = 0; g < NUM_ACTIONS; g++) begin : g_stat
        logic [STAT_W:0] up;
        logic [STAT_W:0] dn;
        logic            served;
        logic [STAT_W-1:0] nx;

        assign served = (state == S_ACT) && (active_id == ID_W'(g));
        assign up     = {1'b0, stat_q[g]} + RISE_V;
        assign dn     = {1'b0, stat_q[g]} - FALL_V;
        assign nx     = served ? (dn[STAT_W] ? '0 : dn[STAT_W-1:0])
                               : ((up > MAX_V) ? MAX_V[STAT_W-1:0] : up[STAT_W-1:0]);
        assign stat_d[g] = tick ? nx : stat_q[g];
        assign stats[g*STAT_W +: STAT_W] = stat_q[g];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            for (int i = 0; i < NUM_ACTIONS; i++) stat_q[i] <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            for (int i = 0; i < NUM_ACTIONS; i++) stat_q[i] <= stat_d[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            active_id <= '0;
            dur_cnt   <= '0;
            aborted   <= 1'b0;
        end else begin
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((|act_req) && !act_abort) begin
                        active_id <= first_id;
                        dur_cnt   <= '0;
                        state     <= S_ACT;
                    end
                end
                S_ACT: begin
                    dur_cnt <= dur_cnt + DUR_W'(1);
                    if (act_abort || !act_req[active_id]) begin
                        state   <= S_IDLE;
                        aborted <= 1'b1;
                    end else if (dur_cnt == DUR_W'(ACTION_CYCLES - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!act_req[active_id]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PET_STAT_ALERT_EN
    localparam int ALERT_LO = (ALERT_LEVEL > 16) ? ALERT_LEVEL - 16 : 0;
    localparam logic [STAT_W:0] ALERT_HI_V = (STAT_W+1)'(ALERT_LEVEL);
    localparam logic [STAT_W:0] ALERT_LO_V = (STAT_W+1)'(ALERT_LO);

    // Judged on the value the stat takes at this edge, so the flag moves with the stat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alert <= '0;
        end else begin
            for (int i = 0; i < NUM_ACTIONS; i++) begin
                if ({1'b0, stat_d[i]} >= ALERT_HI_V) alert[i] <= 1'b1;
                else if ({1'b0, stat_d[i]} < ALERT_LO_V) alert[i] <= 1'b0;
            end
        end
    end
`else
    assign alert = '0;
`endif

endmodule

// File: tb/tb_pet_action_ctrl.sv
// Self-checking bench for pet_action_ctrl: cycle reference model feeds an expectation queue,
// a negedge monitor pops and compares, plus directed checks on the main scenarios.
module tb_pet_action_ctrl;

    localparam int NA   = 3;
    localparam int SW   = 8;
    localparam int SMAX = 20;
    localparam int RISE = 1;
    localparam int FALL = 3;
    localparam int TC   = 4;
    localparam int AC   = 10;
    localparam int AL   = 15;
    localparam int ALO  = (AL > 16) ? AL - 16 : 0;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NA-1:0] act_req = '0;
    logic          act_abort = 1'b0;
    logic [NA*SW-1:0] stats;
    logic          busy;
    logic [1:0]    active_id;
    logic          done;
    logic          aborted;
    logic          tick;
    logic [NA-1:0] alert;

    always #5 clk = ~clk;

    pet_action_ctrl #(
        .NUM_ACTIONS(NA), .STAT_W(SW), .STAT_MAX(SMAX), .RISE_STEP(RISE),
        .FALL_STEP(FALL), .TICK_CYCLES(TC), .ACTION_CYCLES(AC), .ALERT_LEVEL(AL)
    ) dut (
        .clk(clk), .resetn(resetn), .act_req(act_req), .act_abort(act_abort),
        .stats(stats), .busy(busy), .active_id(active_id), .done(done),
        .aborted(aborted), .tick(tick), .alert(alert)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [NA*SW-1:0] stats;
        logic             busy;
        logic             done;
        logic             aborted;
        logic             tick;
        logic [1:0]       id;
        logic [NA-1:0]    alert;
    } obs_t;

    obs_t exp_q[$];
    obs_t e;

    // Reference model: 0 idle, 1 act, 2 done
    int       m_state = 0;
    int       m_id = 0;
    int       m_dur = 0;
    int       m_tcnt = 0;
    int       m_aborted = 0;
    int       m_stat[NA] = '{0, 0, 0};
    logic [NA-1:0] m_alert = '0;
    bit       m_tk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_state = 0; m_id = 0; m_dur = 0; m_tcnt = 0; m_aborted = 0;
            for (int i = 0; i < NA; i++) m_stat[i] = 0;
            m_alert = '0;
            exp_q.delete();
        end else begin
            m_tk = (m_tcnt == TC - 1);
            if (m_tk) begin
                for (int i = 0; i < NA; i++) begin
                    if (m_state == 1 && m_id == i)
                        m_stat[i] = (m_stat[i] >= FALL) ? m_stat[i] - FALL : 0;
                    else
                        m_stat[i] = (m_stat[i] + RISE > SMAX) ? SMAX : m_stat[i] + RISE;
                end
            end
            m_tcnt = m_tk ? 0 : m_tcnt + 1;
            m_aborted = 0;
            case (m_state)
                0: if (act_req != 0 && !act_abort) begin
                       m_id = act_req[0] ? 0 : (act_req[1] ? 1 : 2);
                       m_dur = 0;
                       m_state = 1;
                   end
                1: begin
                       if (act_abort || !act_req[m_id]) begin
                           m_state = 0;
                           m_aborted = 1;
                       end else if (m_dur == AC - 1) begin
                           m_state = 2;
                       end
                       m_dur++;
                   end
                default: if (!act_req[m_id]) m_state = 0;
            endcase
`ifdef PET_STAT_ALERT_EN
            for (int i = 0; i < NA; i++) begin
                if (m_stat[i] >= AL) m_alert[i] = 1'b1;
                else if (m_stat[i] < ALO) m_alert[i] = 1'b0;
            end
`endif
            e.stats   = {8'(m_stat[2]), 8'(m_stat[1]), 8'(m_stat[0])};
            e.busy    = (m_state == 1);
            e.done    = (m_state == 2);
            e.aborted = (m_aborted != 0);
            e.tick    = (m_tcnt == TC - 1);
            e.id      = 2'(m_id);
            e.alert   = m_alert;
            exp_q.push_back(e);
        end
    end

    obs_t x;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("stats", stats, x.stats);
            check("busy", busy, x.busy);
            check("done", done, x.done);
            check("aborted", aborted, x.aborted);
            check("tick", tick, x.tick);
            check("active_id", active_id, x.id);
            check("alert", alert, x.alert);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int cnt, cnt2, w;
    logic [NA-1:0] alert_full;

    initial begin
`ifdef PET_STAT_ALERT_EN
        alert_full = '1;
`else
        alert_full = '0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stats", stats, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_tick", tick, 0);
        check("rst_id", active_id, 0);
        check("rst_alert", alert, 0);
        resetn = 1'b1;

        // 1: idle saturation
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        check("t1_ticks", cnt, 25);
        check("t1_stats_sat", stats, {3{8'd20}});
        check("t1_alert", alert, alert_full);

        // 2: lowest set request wins, full-length action
        act_req = 3'b110;
        cnt = 0; cnt2 = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy) cnt++;
            if (done && cnt2 == 0) begin
                cnt2 = 1;
                check("t2_done_after_busy", cnt, AC);
            end
        end
        check("t2_busy_cycles", cnt, AC);
        check("t2_done_seen", cnt2, 1);
        check("t2_id", active_id, 1);
        check("t2_stat0", stats[7:0], 20);
        check("t2_stat2", stats[23:16], 20);
        act_req = 3'b000;
        @(negedge clk);
        check("t2_done_clear", done, 0);

        // 3: abort by dropping the request at busy cycle 5
        act_req = 3'b100;
        w = 0;
        while (!busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t3_start", busy, 1);
        check("t3_id", active_id, 2);
        repeat (4) @(negedge clk);
        act_req = 3'b000;
        cnt = 0; cnt2 = 0;
        repeat (12) begin
            @(negedge clk);
            if (aborted) cnt++;
            if (done) cnt2++;
        end
        check("t3_aborted_pulses", cnt, 1);
        check("t3_done_never", cnt2, 0);
        check("t3_idle", busy, 0);

        // 4: stat clamps at zero, then recovers
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        w = 0;
        while (stats[7:0] != 8'd2 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("t4_stat0_two", stats[7:0], 2);
        act_req = 3'b001;
        w = 0;
        while (!done && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("t4_done", done, 1);
        check("t4_stat0_clamp", stats[7:0], 0);
        act_req = 3'b000;
        repeat (12) @(negedge clk);
        check("t4_stat0_rise", stats[7:0], 3);

        // 5: asynchronous reset mid-action
        act_req = 3'b010;
        w = 0;
        while (!busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t5_start", busy, 1);
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_stats", stats, 0);
        check("t5_tick", tick, 0);
        check("t5_aborted", aborted, 0);
        check("t5_alert", alert, 0);
        act_req = 3'b000;
        resetn = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (aborted) cnt++;
        end
        check("t5_no_abort_pulse", cnt, 0);

        // 6: alert raised on the way up (or stays low without the feature)
        repeat (70) @(negedge clk);
        check("t6_alert", alert, alert_full);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
